// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipeline_hazard_ctrl_pkg: forwarding-select and controller-state encodings shared by the hazard block
package pipeline_hazard_ctrl_pkg;
  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] HZ_RUN    = 2'd0;
  localparam logic [1:0] HZ_DRAIN  = 2'd1;
  localparam logic [1:0] HZ_HALTED = 2'd2;
endpackage

// File: rtl/pipeline_hazard_ctrl_forwarding_unit.sv
// pipeline_hazard_ctrl_forwarding_unit: EX operand bypass selects, EX/MEM beats MEM/WB, x0 never forwarded
module pipeline_hazard_ctrl_forwarding_unit
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic       ex_mem_valid,
  input  logic       ex_mem_reg_write,
  input  logic       ex_mem_mem_read,
  input  logic [4:0] ex_mem_rd_addr,
  input  logic       mem_wb_valid,
  input  logic       mem_wb_reg_write,
  input  logic [4:0] mem_wb_rd_addr,
  input  logic [4:0] rs1_addr,
  input  logic [4:0] rs2_addr,
  output logic [1:0] forward_a,
  output logic [1:0] forward_b
);
  logic ex_ok, wb_ok;
  // a load in EX/MEM has no data yet, so it cannot be bypassed from that stage
  assign ex_ok = ex_mem_valid & ex_mem_reg_write & ~ex_mem_mem_read & |ex_mem_rd_addr;
  assign wb_ok = mem_wb_valid & mem_wb_reg_write & |mem_wb_rd_addr;
  assign forward_a = (ex_ok && ex_mem_rd_addr == rs1_addr) ? FWD_EXMEM :
                     (wb_ok && mem_wb_rd_addr == rs1_addr) ? FWD_MEMWB : FWD_REG;
  assign forward_b = (ex_ok && ex_mem_rd_addr == rs2_addr) ? FWD_EXMEM :
                     (wb_ok && mem_wb_rd_addr == rs2_addr) ? FWD_MEMWB : FWD_REG;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/redirect, halt-drain-resume sequencing and perf counters for the 5-stage pipe
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             id_ex_valid,
  input  logic [4:0]       id_ex_rs1_addr,
  input  logic [4:0]       id_ex_rs2_addr,
  input  logic [4:0]       id_ex_rd_addr,
  input  logic             id_ex_mem_read,
  input  logic [31:0]      ex_pc,
  input  logic             ex_mem_valid,
  input  logic [4:0]       ex_mem_rd_addr,
  input  logic             ex_mem_reg_write,
  input  logic             ex_mem_mem_read,
  input  logic             mem_wb_valid,
  input  logic [4:0]       mem_wb_rd_addr,
  input  logic             mem_wb_reg_write,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  input  logic             halt_req,
  input  logic             dmem_busy,
  input  logic             resume,
  output logic             stall_if,
  output logic             stall_id,
  output logic             bubble_ex,
  output logic             stall_ex,
  output logic             flush,
  output logic             pc_src,
  output logic [31:0]      new_pc,
  output logic [1:0]       forward_a,
  output logic [1:0]       forward_b,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);
  localparam logic [31:0] DRAIN_INIT = 32'(DRAIN_CYCLES);
  logic [1:0]  state;
  logic [31:0] halt_pc, drain_cnt;
  logic        run, drn, hlt, load_use;
  assign run = state == HZ_RUN;
  assign drn = state == HZ_DRAIN;
  assign hlt = !run && !drn;
  assign load_use = id_valid & id_ex_valid & id_ex_mem_read & |id_ex_rd_addr &
                    ((id_uses_rs1 & id_ex_rd_addr == id_rs1_addr) | (id_uses_rs2 & id_ex_rd_addr == id_rs2_addr));
  pipeline_hazard_ctrl_forwarding_unit u_fwd (
    .ex_mem_valid     (ex_mem_valid),
    .ex_mem_reg_write (ex_mem_reg_write),
    .ex_mem_mem_read  (ex_mem_mem_read),
    .ex_mem_rd_addr   (ex_mem_rd_addr),
    .mem_wb_valid     (mem_wb_valid),
    .mem_wb_reg_write (mem_wb_reg_write),
    .mem_wb_rd_addr   (mem_wb_rd_addr),
    .rs1_addr         (id_ex_rs1_addr),
    .rs2_addr         (id_ex_rs2_addr),
    .forward_a        (forward_a),
    .forward_b        (forward_b)
  );
  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    bubble_ex = 1'b0;
    stall_ex  = 1'b0;
    flush     = 1'b0;
    pc_src    = 1'b0;
    halted    = 1'b0;
    new_pc    = !reset ? 32'd0 : hlt ? halt_pc + 32'd4 : branch_target;
    if (reset) begin
      if (run) begin
        if (dmem_busy) {stall_if, stall_id, stall_ex} = 3'b111;
        else if (halt_req) flush = 1'b1;
        else if (branch_taken) {pc_src, flush} = 2'b11;
        else if (load_use) {stall_if, stall_id, bubble_ex} = 3'b111;
      end else if (drn) begin
        {stall_if, stall_id} = 2'b11;
        stall_ex = dmem_busy;
      end else begin
        // the resume cycle releases the front end so the redirect is taken
        {stall_if, stall_id, halted} = {3{~resume}};
        {pc_src, flush} = {2{resume}};
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= HZ_RUN;
      halt_pc     <= '0;
      drain_cnt   <= '0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall_if && !(&stall_count)) stall_count <= stall_count + 1'b1;
      if (flush && !(&flush_count)) flush_count <= flush_count + 1'b1;
      if (run && !dmem_busy && halt_req) begin
        state     <= HZ_DRAIN;
        halt_pc   <= ex_pc;
        drain_cnt <= DRAIN_INIT;
      end else if (drn && !dmem_busy) begin
        drain_cnt <= drain_cnt == 32'd0 ? 32'd0 : drain_cnt - 32'd1;
        state     <= drain_cnt <= 32'd1 ? HZ_HALTED : HZ_DRAIN;
      end else if (hlt && resume) begin
        state <= HZ_RUN;
      end
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: scoreboard bench for the hazard controller, one task per scenario
module tb_pipeline_hazard_ctrl;
  logic        clk = 1'b0, reset;
  logic        id_valid, id_uses_rs1, id_uses_rs2, id_ex_valid, id_ex_mem_read;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_ex_rs1_addr, id_ex_rs2_addr, id_ex_rd_addr;
  logic [31:0] ex_pc, branch_target;
  logic        ex_mem_valid, ex_mem_reg_write, ex_mem_mem_read, mem_wb_valid, mem_wb_reg_write;
  logic [4:0]  ex_mem_rd_addr, mem_wb_rd_addr;
  logic        branch_taken, halt_req, dmem_busy, resume;
  logic        stall_if, stall_id, bubble_ex, stall_ex, flush, pc_src, halted;
  logic [31:0] new_pc, stall_count, flush_count;
  logic [1:0]  forward_a, forward_b;
  int checks = 0, failures = 0;
  typedef struct {string nm; logic [6:0] ctl; logic [6:0] msk; logic pchk; logic [31:0] pc; logic [3:0] fwd;} ent_t;
  ent_t sb[$], obsq[$];
  ent_t e, o;
  logic [31:0] s0, f0;
  localparam logic [6:0] ALL = 7'h7f;
  always #5 clk = ~clk;
  pipeline_hazard_ctrl dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_ex_valid(id_ex_valid),
    .id_ex_rs1_addr(id_ex_rs1_addr), .id_ex_rs2_addr(id_ex_rs2_addr), .id_ex_rd_addr(id_ex_rd_addr),
    .id_ex_mem_read(id_ex_mem_read), .ex_pc(ex_pc), .ex_mem_valid(ex_mem_valid), .ex_mem_rd_addr(ex_mem_rd_addr),
    .ex_mem_reg_write(ex_mem_reg_write), .ex_mem_mem_read(ex_mem_mem_read), .mem_wb_valid(mem_wb_valid),
    .mem_wb_rd_addr(mem_wb_rd_addr), .mem_wb_reg_write(mem_wb_reg_write), .branch_taken(branch_taken),
    .branch_target(branch_target), .halt_req(halt_req), .dmem_busy(dmem_busy), .resume(resume),
    .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex), .stall_ex(stall_ex), .flush(flush),
    .pc_src(pc_src), .new_pc(new_pc), .forward_a(forward_a), .forward_b(forward_b), .halted(halted),
    .stall_count(stall_count), .flush_count(flush_count)
  );
  // ctl bit order: stall_if stall_id bubble_ex stall_ex flush pc_src halted
  task automatic idle();
    {id_valid, id_uses_rs1, id_uses_rs2, id_ex_valid, id_ex_mem_read} = '0;
    {id_rs1_addr, id_rs2_addr, id_ex_rs1_addr, id_ex_rs2_addr, id_ex_rd_addr} = '0;
    {ex_mem_valid, ex_mem_reg_write, ex_mem_mem_read, mem_wb_valid, mem_wb_reg_write} = '0;
    {ex_mem_rd_addr, mem_wb_rd_addr} = '0;
    {branch_taken, halt_req, dmem_busy, resume} = '0;
    ex_pc = '0;
    branch_target = '0;
  endtask
  task automatic tick(input string nm, input logic [6:0] c, input logic [6:0] m, input logic pchk,
                      input logic [31:0] p, input logic [3:0] f);
    ent_t x;
    sb.push_back('{nm, c, m, pchk, p, f});
    #1;
    x = '{nm, {stall_if, stall_id, bubble_ex, stall_ex, flush, pc_src, halted}, ALL, 1'b1, new_pc, {forward_a, forward_b}};
    obsq.push_back(x);
    @(negedge clk);
  endtask
  task automatic test_reset();
    reset = 1'b0;
    halt_req = 1'b1; branch_taken = 1'b1; branch_target = 32'h40; resume = 1'b1;
    tick("rst_outputs", 7'b0, ALL, 1'b1, 32'h0, 4'b0000);
    idle();
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obsq.pop_front(); checks++;
      if (((o.ctl ^ e.ctl) & e.msk) !== 7'b0 || (e.pchk && o.pc !== e.pc) || o.fwd !== e.fwd) begin
        failures++;
        $display("FAIL %s ctl=%b want=%b pc=%h want=%h fwd=%b want=%b", e.nm, o.ctl, e.ctl, o.pc, e.pc, o.fwd, e.fwd);
      end
    end
    checks++;
    if (stall_count !== 32'd0 || flush_count !== 32'd0) begin
      failures++;
      $display("FAIL rst_counters stall=%0d flush=%0d want 0/0", stall_count, flush_count);
    end
    reset = 1'b1;
  endtask
  task automatic test_forwarding();
    idle();
    id_ex_rs1_addr = 5'd3; id_ex_rs2_addr = 5'd7;
    {ex_mem_valid, ex_mem_reg_write, ex_mem_rd_addr} = {2'b11, 5'd3};
    {mem_wb_valid, mem_wb_reg_write, mem_wb_rd_addr} = {2'b11, 5'd3};
    tick("fwd_exmem_wins", 7'b0, ALL, 1'b0, 32'h0, 4'b1000);
    {ex_mem_rd_addr, mem_wb_rd_addr, id_ex_rs1_addr} = '0;
    tick("fwd_x0", 7'b0, ALL, 1'b0, 32'h0, 4'b0000);
    {ex_mem_rd_addr, mem_wb_rd_addr, id_ex_rs1_addr} = {5'd3, 5'd3, 5'd3};
    ex_mem_mem_read = 1'b1;
    tick("fwd_exmem_load", 7'b0, ALL, 1'b0, 32'h0, 4'b0100);
    ex_mem_mem_read = 1'b0; ex_mem_rd_addr = 5'd7; id_ex_rs2_addr = 5'd3; id_ex_rs1_addr = 5'd7;
    tick("fwd_ab_split", 7'b0, ALL, 1'b0, 32'h0, 4'b1001);
    ex_mem_valid = 1'b0;
    tick("fwd_exmem_invalid", 7'b0, ALL, 1'b0, 32'h0, 4'b0001);
    mem_wb_reg_write = 1'b0;
    tick("fwd_none", 7'b0, ALL, 1'b0, 32'h0, 4'b0000);
    idle();
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obsq.pop_front(); checks++;
      if (((o.ctl ^ e.ctl) & e.msk) !== 7'b0 || (e.pchk && o.pc !== e.pc) || o.fwd !== e.fwd) begin
        failures++;
        $display("FAIL %s ctl=%b want=%b pc=%h want=%h fwd=%b want=%b", e.nm, o.ctl, e.ctl, o.pc, e.pc, o.fwd, e.fwd);
      end
    end
  endtask
  task automatic test_load_use();
    idle();
    {id_ex_valid, id_ex_mem_read, id_ex_rd_addr} = {2'b11, 5'd5};
    {id_valid, id_uses_rs1, id_rs1_addr} = {2'b11, 5'd5};
    tick("lu_stall", 7'b1110000, ALL, 1'b0, 32'h0, 4'b0000);
    id_ex_valid = 1'b0;
    {ex_mem_valid, ex_mem_reg_write, ex_mem_mem_read, ex_mem_rd_addr} = {3'b111, 5'd5};
    tick("lu_bubble_clears", 7'b0, ALL, 1'b0, 32'h0, 4'b0000);
    idle();
    id_ex_valid = 1'b1; id_ex_rs1_addr = 5'd5;
    {mem_wb_valid, mem_wb_reg_write, mem_wb_rd_addr} = {2'b11, 5'd5};
    tick("lu_fwd_memwb", 7'b0, ALL, 1'b0, 32'h0, 4'b0100);
    idle();
    {id_ex_valid, id_ex_mem_read, id_ex_rd_addr} = {2'b11, 5'd0};
    {id_valid, id_uses_rs1, id_rs1_addr} = {2'b11, 5'd0};
    tick("lu_x0_no_stall", 7'b0, ALL, 1'b0, 32'h0, 4'b0000);
    id_ex_rd_addr = 5'd9; id_uses_rs1 = 1'b0; id_rs2_addr = 5'd9;
    tick("lu_rs2_unused", 7'b0, ALL, 1'b0, 32'h0, 4'b0000);
    id_uses_rs2 = 1'b1;
    tick("lu_rs2_stall", 7'b1110000, ALL, 1'b0, 32'h0, 4'b0000);
    idle();
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obsq.pop_front(); checks++;
      if (((o.ctl ^ e.ctl) & e.msk) !== 7'b0 || (e.pchk && o.pc !== e.pc) || o.fwd !== e.fwd) begin
        failures++;
        $display("FAIL %s ctl=%b want=%b pc=%h want=%h fwd=%b want=%b", e.nm, o.ctl, e.ctl, o.pc, e.pc, o.fwd, e.fwd);
      end
    end
  endtask
  task automatic test_branch();
    idle();
    s0 = stall_count; f0 = flush_count;
    branch_taken = 1'b1; branch_target = 32'h40;
    {id_ex_valid, id_ex_mem_read, id_ex_rd_addr} = {2'b11, 5'd5};
    {id_valid, id_uses_rs1, id_rs1_addr} = {2'b11, 5'd5};
    tick("br_redirect", 7'b0000110, ALL, 1'b1, 32'h40, 4'b0000);
    idle();
    tick("br_after", 7'b0, ALL, 1'b0, 32'h0, 4'b0000);
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obsq.pop_front(); checks++;
      if (((o.ctl ^ e.ctl) & e.msk) !== 7'b0 || (e.pchk && o.pc !== e.pc) || o.fwd !== e.fwd) begin
        failures++;
        $display("FAIL %s ctl=%b want=%b pc=%h want=%h fwd=%b want=%b", e.nm, o.ctl, e.ctl, o.pc, e.pc, o.fwd, e.fwd);
      end
    end
    checks++;
    if (flush_count - f0 !== 32'd1 || stall_count - s0 !== 32'd0) begin
      failures++;
      $display("FAIL br_counters flush_delta=%0d stall_delta=%0d want 1/0", flush_count - f0, stall_count - s0);
    end
  endtask
  task automatic test_busy();
    idle();
    s0 = stall_count; f0 = flush_count;
    branch_taken = 1'b1; branch_target = 32'h80;
    dmem_busy = 1'b1;
    for (int i = 0; i < 3; i++) tick("busy_freeze", 7'b1101000, ALL, 1'b0, 32'h0, 4'b0000);
    dmem_busy = 1'b0;
    tick("busy_release_branch", 7'b0000110, ALL, 1'b1, 32'h80, 4'b0000);
    idle();
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obsq.pop_front(); checks++;
      if (((o.ctl ^ e.ctl) & e.msk) !== 7'b0 || (e.pchk && o.pc !== e.pc) || o.fwd !== e.fwd) begin
        failures++;
        $display("FAIL %s ctl=%b want=%b pc=%h want=%h fwd=%b want=%b", e.nm, o.ctl, e.ctl, o.pc, e.pc, o.fwd, e.fwd);
      end
    end
    checks++;
    if (stall_count - s0 !== 32'd3 || flush_count - f0 !== 32'd1) begin
      failures++;
      $display("FAIL busy_counters stall_delta=%0d flush_delta=%0d want 3/1", stall_count - s0, flush_count - f0);
    end
  endtask
  task automatic test_halt();
    idle();
    s0 = stall_count; f0 = flush_count;
    halt_req = 1'b1; ex_pc = 32'h100; branch_taken = 1'b1; branch_target = 32'h40;
    tick("halt_flush", 7'b0000100, ALL, 1'b0, 32'h0, 4'b0000);
    idle();
    dmem_busy = 1'b1;
    tick("drain_busy", 7'b1101000, ALL, 1'b0, 32'h0, 4'b0000);
    dmem_busy = 1'b0;
    tick("drain_2", 7'b1100000, ALL, 1'b0, 32'h0, 4'b0000);
    tick("drain_3", 7'b1100000, ALL, 1'b0, 32'h0, 4'b0000);
    tick("halted_1", 7'b1100001, ALL, 1'b0, 32'h0, 4'b0000);
    tick("halted_2", 7'b1100001, ALL, 1'b0, 32'h0, 4'b0000);
    resume = 1'b1;
    tick("resume", 7'b0000110, 7'b0000111, 1'b1, 32'h104, 4'b0000);
    resume = 1'b0;
    tick("resume_run", 7'b0, ALL, 1'b0, 32'h0, 4'b0000);
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obsq.pop_front(); checks++;
      if (((o.ctl ^ e.ctl) & e.msk) !== 7'b0 || (e.pchk && o.pc !== e.pc) || o.fwd !== e.fwd) begin
        failures++;
        $display("FAIL %s ctl=%b want=%b pc=%h want=%h fwd=%b want=%b", e.nm, o.ctl, e.ctl, o.pc, e.pc, o.fwd, e.fwd);
      end
    end
    checks++;
    if (stall_count - s0 !== 32'd5 || flush_count - f0 !== 32'd2) begin
      failures++;
      $display("FAIL halt_counters stall_delta=%0d flush_delta=%0d want 5/2", stall_count - s0, flush_count - f0);
    end
  endtask
  task automatic test_reset_mid_drain();
    idle();
    halt_req = 1'b1; ex_pc = 32'h200;
    tick("md_halt", 7'b0000100, ALL, 1'b0, 32'h0, 4'b0000);
    idle();
    tick("md_drain", 7'b1100000, ALL, 1'b0, 32'h0, 4'b0000);
    reset = 1'b0;
    tick("md_reset", 7'b0, ALL, 1'b1, 32'h0, 4'b0000);
    reset = 1'b1;
    tick("md_run", 7'b0, ALL, 1'b0, 32'h0, 4'b0000);
    checks++;
    if (stall_count !== 32'd0 || flush_count !== 32'd0) begin
      failures++;
      $display("FAIL md_counters stall=%0d flush=%0d want 0/0", stall_count, flush_count);
    end
    halt_req = 1'b1; ex_pc = 32'hFFFF_FFFC;
    tick("md_halt2", 7'b0000100, ALL, 1'b0, 32'h0, 4'b0000);
    idle();
    tick("md_drain2_1", 7'b1100000, ALL, 1'b0, 32'h0, 4'b0000);
    tick("md_drain2_2", 7'b1100000, ALL, 1'b0, 32'h0, 4'b0000);
    tick("md_halted2", 7'b1100001, ALL, 1'b0, 32'h0, 4'b0000);
    resume = 1'b1;
    tick("md_resume_wrap", 7'b0000110, 7'b0000111, 1'b1, 32'h0, 4'b0000);
    idle();
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obsq.pop_front(); checks++;
      if (((o.ctl ^ e.ctl) & e.msk) !== 7'b0 || (e.pchk && o.pc !== e.pc) || o.fwd !== e.fwd) begin
        failures++;
        $display("FAIL %s ctl=%b want=%b pc=%h want=%h fwd=%b want=%b", e.nm, o.ctl, e.ctl, o.pc, e.pc, o.fwd, e.fwd);
      end
    end
    checks++;
    if (stall_count !== 32'd3 || flush_count !== 32'd2) begin
      failures++;
      $display("FAIL md_counters_after stall=%0d flush=%0d want 3/2", stall_count, flush_count);
    end
  endtask
  initial begin
    idle();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_busy();
    test_halt();
    test_reset_mid_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage RV32I pipeline (IF/ID/EX/MEM/WB).
- Generates per-stage stall, bubble and flush, the PC redirect (pc_src/new_pc) and the EX operand forwarding selects.
- Sequences halt/drain/resume for ECALL/EBREAK.
- Keeps saturating stall and flush performance counters.
- Instantiated once in the core top, between the stage modules.

Parameters:
DRAIN_CYCLES, 2, cycles to let MEM/WB retire older instructions after a halt request
CNT_W, 32, width of performance counters

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low
id_valid  in  1  IF/ID holds a valid instruction
id_rs1_addr  in  5  source register 1 of the instruction in ID
id_rs2_addr  in  5  source register 2 of the instruction in ID
id_uses_rs1  in  1  instruction in ID reads rs1
id_uses_rs2  in  1  instruction in ID reads rs2
id_ex_valid  in  1  ID/EX holds a valid instruction
id_ex_rs1_addr  in  5  rs1 of the instruction in EX
id_ex_rs2_addr  in  5  rs2 of the instruction in EX
id_ex_rd_addr  in  5  destination register of the instruction in EX
id_ex_mem_read  in  1  instruction in EX is a load
ex_pc  in  32  PC of the instruction in EX
ex_mem_valid  in  1  EX/MEM holds a valid instruction
ex_mem_rd_addr  in  5  destination register in EX/MEM
ex_mem_reg_write  in  1  EX/MEM instruction writes a register
ex_mem_mem_read  in  1  EX/MEM instruction is a load
mem_wb_valid  in  1  MEM/WB holds a valid instruction
mem_wb_rd_addr  in  5  destination register in MEM/WB
mem_wb_reg_write  in  1  MEM/WB instruction writes a register
branch_taken  in  1  EX resolved a taken branch or jump
branch_target  in  32  redirect target from EX
halt_req  in  1  ECALL/EBREAK is valid in EX
dmem_busy  in  1  data memory multi-cycle wait (level)
resume  in  1  single-cycle pulse that leaves HALTED
stall_if  out  1  freeze PC and IF/ID
stall_id  out  1  freeze the ID/EX input side
bubble_ex  out  1  load a NOP into ID/EX
stall_ex  out  1  freeze ID/EX, EX/MEM and MEM/WB
flush  out  1  invalidate IF/ID and ID/EX
pc_src  out  1  select new_pc
new_pc  out  32  redirect address
forward_a  out  2  00 register file, 01 MEM/WB, 10 EX/MEM
forward_b  out  2  same encoding as forward_a
halted  out  1  core is halted
stall_count  out  CNT_W  cycles with stall_if=1
flush_count  out  CNT_W  cycles with flush=1

Behaviour:
Reset (reset=0 at posedge):
- Next state is RUN; halt_pc, drain counter and both perf counters clear to 0.
- Control and status outputs (stall_if, stall_id, bubble_ex, stall_ex, flush, pc_src, halted) deassert and new_pc=0 while reset=0.
- Applies from any state, including mid-DRAIN and HALTED.

Forwarding (combinational, evaluated in every state):
- forward_a=10 if ex_mem_valid & ex_mem_reg_write & !ex_mem_mem_read & rd!=0 & ex_mem_rd_addr==id_ex_rs1_addr.
- Else forward_a=01 if mem_wb_valid & mem_wb_reg_write & rd!=0 & mem_wb_rd_addr==id_ex_rs1_addr.
- Else forward_a=00. forward_b is identical using id_ex_rs2_addr.
- x0 is never forwarded.

Load-use detection:
- Condition: id_valid & id_ex_valid & id_ex_mem_read & id_ex_rd_addr!=0 & ((id_uses_rs1 & rd==id_rs1_addr) | (id_uses_rs2 & rd==id_rs2_addr)).
- Response: stall_if=stall_id=bubble_ex=1 for exactly one cycle; the condition clears itself once the bubble is inserted.

State RUN, priority (highest first):
1. dmem_busy: stall_if=stall_id=stall_ex=1, pc_src=0, flush=0. branch_taken and halt_req are ignored; EX is frozen, so both re-present once busy drops.
2. halt_req: latch halt_pc=ex_pc, flush=1 for one cycle, load drain counter with DRAIN_CYCLES, go to DRAIN.
3. branch_taken: pc_src=1, new_pc=branch_target, flush=1 for one cycle. A simultaneous load-use stall is suppressed.
4. Load-use stall, as above.

State DRAIN:
- stall_if=stall_id=1 every cycle.
- Counter decrements on cycles with dmem_busy=0; while dmem_busy=1 it holds and stall_ex=1.
- When the counter reaches 0, go to HALTED.

State HALTED:
- halted=1, stall_if=stall_id=1.
- On resume: pc_src=1, new_pc=halt_pc+4 (modulo 2^32), flush=1 for that cycle, halted=0, go to RUN.

Counters:
- stall_count increments on every cycle with stall_if=1 (including DRAIN and HALTED).
- flush_count increments on every cycle with flush=1.
- Both saturate at all-ones.

Decomposition:
- Shared constants package/include: FWD_REG/FWD_MEMWB/FWD_EXMEM encodings; HZ_RUN/HZ_DRAIN/HZ_HALTED state encodings.
- One natural sub-module: forwarding_unit, purely combinational, producing forward_a/forward_b.

Test Plan:
1. Load-use: lw rd=5 in EX, ID add uses rs1=5 -> stall_if/stall_id/bubble_ex=1 for one cycle; two cycles later, with the lw in MEM/WB and the add in EX, forward_a=01.
2. Forwarding priority: EX/MEM rd=3 and MEM/WB rd=3, id_ex_rs1=3 -> forward_a=10. Same with rd=0 -> 00. EX/MEM as a load -> 01.
3. Branch: branch_taken=1, target 0x40, concurrent load-use -> pc_src=1, new_pc=0x40, flush=1 for one cycle, no stall; flush_count=1.
4. dmem_busy for 3 cycles with branch_taken held -> stall_if/stall_id/stall_ex high for 3 cycles with pc_src=0; pc_src=1 on the first cycle after; stall_count=3.
5. Halt: halt_req, ex_pc=0x100, one busy cycle during drain -> flush for 1 cycle, DRAIN lasts 3 cycles, then halted=1; resume -> new_pc=0x104, pc_src=1, flush=1, halted=0.
6. reset=0 asserted mid-DRAIN -> next edge: RUN, all control outputs 0, counters 0; a later halt_req drains normally.
